// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/exec1/exec2 phase machinery:
// opcode constants, instruction class enum and default field widths.
package cpu_pkg;

   localparam int IW_DEF  = 16;
   localparam int OPW_DEF = 4;
   localparam int CW_DEF  = 4;

   localparam logic [3:0] OP_LOAD  = 4'h8;
   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_SHL   = 4'hA;
   localparam logic [3:0] OP_SHR   = 4'hB;
   localparam logic [3:0] OP_MUL   = 4'hC;

   typedef enum logic [1:0] {
      CLS_ALU,
      CLS_MEM,
      CLS_ITER,
      CLS_ILL
   } op_class_t;

endpackage

// File: rtl/op_class_dec.sv
// Combinational opcode classifier: maps an opcode to its
// execution class (ALU, MEM, ITER or ILL).
module op_class_dec
   import cpu_pkg::*;
#(
   parameter int OPW = OPW_DEF
) (
   input  logic [OPW-1:0] op,
   output op_class_t      cls
);

   localparam logic [OPW-1:0] LD  = OPW'(OP_LOAD);
   localparam logic [OPW-1:0] ST  = OPW'(OP_STORE);
   localparam logic [OPW-1:0] SHL = OPW'(OP_SHL);
   localparam logic [OPW-1:0] MUL = OPW'(OP_MUL);

   always_comb begin
      cls = CLS_ILL;
      unique case (1'b1)
         (op < LD):               cls = CLS_ALU;
         (op == LD || op == ST):  cls = CLS_MEM;
         (op >= SHL && op <= MUL): cls = CLS_ITER;
         default:                 cls = CLS_ILL;
      endcase
   end

endmodule

// File: rtl/exec_responder.sv
// Answering side of the phase sequencer: latches the instruction at
// fetch, returns Extra/Loop and tracks iterations and protocol errors.
module exec_responder
   import cpu_pkg::*;
#(
   parameter int IW  = IW_DEF,
   parameter int OPW = OPW_DEF,
   parameter int CW  = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fetch,
   input  logic          exec1,
   input  logic          exec2,
   input  logic [IW-1:0] instr_in,
   output logic          extra,
   output logic          loop,
   output logic [IW-1:0] ir,
   output logic [CW-1:0] iter_left,
   output logic          last_iter,
   output logic          instr_done,
   output logic          illegal_op,
   output logic          proto_err
);

   op_class_t     cls;
   op_class_t     cls_dec;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_load;
   logic [CW-1:0] count;
   logic          seen_fetch;
   logic          multi;
   logic          viol;

   op_class_dec #(.OPW(OPW)) u_dec (
      .op  (instr_in[IW-1:IW-OPW]),
      .cls (cls_dec)
   );

   assign count = instr_in[CW-1:0];

   // A zero count still runs the instruction once.
   always_comb begin
      cnt_load = CW'(1);
      if (cls_dec == CLS_ITER && count != '0)
         cnt_load = count;
   end

   assign loop       = exec1 & (cls == CLS_ITER) & (cnt > CW'(1));
   assign extra      = exec1 & (cls == CLS_MEM);
   assign last_iter  = exec1 & (cnt == CW'(1));
   assign instr_done = (exec1 & ~loop & ~extra) | exec2;
   assign iter_left  = cnt;

   assign multi = (fetch & exec1) | (fetch & exec2) | (exec1 & exec2);
   assign viol  = multi
                | (exec2 & (cls != CLS_MEM))
                | ((exec1 | exec2) & ~seen_fetch);

   always_ff @(posedge clk) begin
      if (reset) begin
         ir         <= '0;
         cls        <= CLS_ALU;
         cnt        <= '0;
         illegal_op <= 1'b0;
         seen_fetch <= 1'b0;
         proto_err  <= 1'b0;
      end else begin
         if (fetch) begin
            ir         <= instr_in;
            cls        <= cls_dec;
            illegal_op <= (cls_dec == CLS_ILL);
            cnt        <= cnt_load;
            seen_fetch <= 1'b1;
         end else if (exec1 && cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
         end
         if (viol)
            proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_exec_responder.sv
// Directed bench for exec_responder: walks each instruction class,
// the count boundaries, mid-instruction refetch, reset and protocol errors.
module tb_exec_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch;
   logic        exec1;
   logic        exec2;
   logic [15:0] instr_in;
   logic        extra;
   logic        loop;
   logic [15:0] ir;
   logic [3:0]  iter_left;
   logic        last_iter;
   logic        instr_done;
   logic        illegal_op;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exec_responder dut (
      .clk        (clk),
      .reset      (reset),
      .fetch      (fetch),
      .exec1      (exec1),
      .exec2      (exec2),
      .instr_in   (instr_in),
      .extra      (extra),
      .loop       (loop),
      .ir         (ir),
      .iter_left  (iter_left),
      .last_iter  (last_iter),
      .instr_done (instr_done),
      .illegal_op (illegal_op),
      .proto_err  (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs just after the edge; checks then see
   // the state from the previous edge plus these strobes.
   task automatic cyc(input logic r, input logic f, input logic e1,
                      input logic e2, input logic [15:0] ins);
      @(posedge clk);
      #1;
      reset = r; fetch = f; exec1 = e1; exec2 = e2; instr_in = ins;
      #1;
   endtask

   task automatic comb(input string tag, input logic ex, input logic lp,
                       input logic li, input logic dn);
      chk({tag, ".extra"}, 32'(extra), 32'(ex));
      chk({tag, ".loop"}, 32'(loop), 32'(lp));
      chk({tag, ".last"}, 32'(last_iter), 32'(li));
      chk({tag, ".done"}, 32'(instr_done), 32'(dn));
   endtask

   initial begin
      reset = 1'b1; fetch = 1'b0; exec1 = 1'b0; exec2 = 1'b0;
      instr_in = 16'h0;
      cyc(1, 0, 0, 0, 16'h0);
      cyc(1, 0, 0, 0, 16'h0);
      cyc(0, 0, 0, 0, 16'h0);
      chk("rst.ir", 32'(ir), 32'h0);
      chk("rst.iter", 32'(iter_left), 32'h0);
      chk("rst.ill", 32'(illegal_op), 32'h0);
      chk("rst.perr", 32'(proto_err), 32'h0);
      comb("rst", 0, 0, 0, 0);

      // ALU 0x3000
      cyc(0, 1, 0, 0, 16'h3000);
      comb("alu.f", 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 16'h0);
      chk("alu.ir", 32'(ir), 32'h3000);
      chk("alu.iter", 32'(iter_left), 32'h1);
      comb("alu.e1", 0, 0, 1, 1);

      // LOAD 0x8000
      cyc(0, 1, 0, 0, 16'h8000);
      cyc(0, 0, 1, 0, 16'h0);
      comb("ld.e1", 1, 0, 1, 0);
      cyc(0, 0, 0, 1, 16'h0);
      comb("ld.e2", 0, 0, 0, 1);

      // SHL 0xA005: five exec1 cycles
      cyc(0, 1, 0, 0, 16'hA005);
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 1, 0, 16'h0);
         chk($sformatf("shl5.iter%0d", i), 32'(iter_left), 32'(5 - i));
         comb($sformatf("shl5.%0d", i), 0, (i < 4), (i == 4), (i == 4));
      end

      // SHL 0xA000: count 0 runs once
      cyc(0, 1, 0, 0, 16'hA000);
      cyc(0, 0, 1, 0, 16'h0);
      chk("shl0.iter", 32'(iter_left), 32'h1);
      comb("shl0", 0, 0, 1, 1);

      // Illegal opcode 0xE executes as ALU
      cyc(0, 1, 0, 0, 16'hE123);
      cyc(0, 0, 1, 0, 16'h0);
      chk("ill.flag", 32'(illegal_op), 32'h1);
      comb("ill", 0, 0, 1, 1);

      // Maximum count 15, no wrap
      cyc(0, 1, 0, 0, 16'hA00F);
      chk("max.ill", 32'(illegal_op), 32'h1);
      for (int i = 0; i < 15; i++) begin
         cyc(0, 0, 1, 0, 16'h0);
         if (i == 0)
            chk("max.ill0", 32'(illegal_op), 32'h0);
         chk($sformatf("max.iter%0d", i), 32'(iter_left), 32'(15 - i));
         chk($sformatf("max.loop%0d", i), 32'(loop), 32'(i < 14));
      end

      // Refetch mid-instruction discards the old count
      cyc(0, 1, 0, 0, 16'hB005);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(0, 0, 1, 0, 16'h0);
      chk("refetch.mid", 32'(iter_left), 32'h4);
      cyc(0, 1, 0, 0, 16'hC003);
      cyc(0, 0, 1, 0, 16'h0);
      chk("refetch.iter", 32'(iter_left), 32'h3);
      comb("refetch", 0, 1, 0, 0);
      chk("clean.perr", 32'(proto_err), 32'h0);

      // Reset during third exec1 of 0xA005
      cyc(0, 1, 0, 0, 16'hA005);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(1, 0, 1, 0, 16'h0);
      cyc(0, 0, 0, 0, 16'h0);
      chk("rst2.ir", 32'(ir), 32'h0);
      chk("rst2.iter", 32'(iter_left), 32'h0);
      chk("rst2.perr", 32'(proto_err), 32'h0);
      comb("rst2", 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 16'h0);
      chk("nofetch.loop", 32'(loop), 32'h0);
      cyc(0, 0, 0, 0, 16'h0);
      chk("nofetch.perr", 32'(proto_err), 32'h1);

      // fetch and exec1 together
      cyc(1, 0, 0, 0, 16'h0);
      cyc(0, 0, 0, 0, 16'h0);
      chk("rst3.perr", 32'(proto_err), 32'h0);
      cyc(0, 1, 0, 0, 16'h3000);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(0, 1, 1, 0, 16'h3000);
      cyc(0, 0, 0, 0, 16'h0);
      chk("multi.perr", 32'(proto_err), 32'h1);
      cyc(0, 0, 0, 0, 16'h0);
      cyc(0, 0, 0, 0, 16'h0);
      chk("multi.sticky", 32'(proto_err), 32'h1);

      // exec2 after an ALU op
      cyc(1, 0, 0, 0, 16'h0);
      cyc(0, 1, 0, 0, 16'h3000);
      cyc(0, 0, 1, 0, 16'h0);
      chk("e2alu.pre", 32'(proto_err), 32'h0);
      cyc(0, 0, 0, 1, 16'h0);
      comb("e2alu", 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 16'h0);
      chk("e2alu.perr", 32'(proto_err), 32'h1);
      cyc(0, 1, 0, 0, 16'h8000);
      cyc(0, 0, 1, 0, 16'h0);
      chk("e2alu.sticky", 32'(proto_err), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
